// File: rtl/vendig_machine.sv
// Vending machine controller: accepts a start request with a product choice,
// collects coins until the price is reached, then issues a one-cycle sale
// pulse with the dispensed product code and the change owed.
// Every output comes straight from a register.
module vendig_machine #(
  parameter int PRICE_CHOC  = 2,
  parameter int PRICE_DRINK = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       choice,
  input  logic [1:0] coins,
  output logic       done,
  output logic [1:0] product,
  output logic [1:0] change
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COLLECT  = 2'd1;
  localparam logic [1:0] DISPENSE = 2'd2;

  localparam logic [1:0] PROD_NONE  = 2'b00;
  localparam logic [1:0] PROD_CHOC  = 2'b01;
  localparam logic [1:0] PROD_DRINK = 2'b10;

  logic [1:0] state_r;
  logic [2:0] credit_r;
  logic       sel_r;          // 0 = chocolate, 1 = drink, latched at start

  logic [2:0] price_s;
  logic [2:0] sum_s;
  logic       paid_s;
  logic [1:0] change_s;
  logic [1:0] prod_code_s;

  // Price lookup, running total with this cycle's coin, and the sale decision.
  // Credit never exceeds price-1 while collecting, so the sum fits in 3 bits.
  always_comb begin
    price_s     = 3'd0;
    prod_code_s = PROD_NONE;
    if (sel_r) begin
      price_s     = 3'(PRICE_DRINK);
      prod_code_s = PROD_DRINK;
    end else begin
      price_s     = 3'(PRICE_CHOC);
      prod_code_s = PROD_CHOC;
    end
    sum_s    = credit_r + {1'b0, coins};
    paid_s   = (sum_s >= price_s);
    change_s = 2'(sum_s - price_s);
  end

  // Purchase state machine with registered sale outputs; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      credit_r <= 3'd0;
      sel_r    <= 1'b0;
      done     <= 1'b0;
      product  <= PROD_NONE;
      change   <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          done    <= 1'b0;
          product <= PROD_NONE;
          change  <= 2'b00;
          if (start) begin
            state_r  <= COLLECT;
            sel_r    <= choice;
            credit_r <= 3'd0;
          end else begin
            state_r  <= IDLE;
          end
        end
        COLLECT: begin
          if (paid_s) begin
            state_r  <= DISPENSE;
            credit_r <= 3'd0;
            done     <= 1'b1;
            product  <= prod_code_s;
            change   <= change_s;
          end else begin
            state_r  <= COLLECT;
            credit_r <= sum_s;
            done     <= 1'b0;
            product  <= PROD_NONE;
            change   <= 2'b00;
          end
        end
        DISPENSE: begin
          state_r  <= IDLE;
          credit_r <= 3'd0;
          done     <= 1'b0;
          product  <= PROD_NONE;
          change   <= 2'b00;
        end
        default: begin
          state_r  <= IDLE;
          credit_r <= 3'd0;
          sel_r    <= 1'b0;
          done     <= 1'b0;
          product  <= PROD_NONE;
          change   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vendig_machine.sv
// Directed bench for vendig_machine. Each scenario task holds a table of
// per-cycle steps {rst, start, choice, coins[1:0], expected {done, product, change}}:
// the inputs are applied, one clock edge passes, and the registered outputs
// are compared 1 time unit after that edge.
module tb_vendig_machine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       choice = 1'b0;
  logic [1:0] coins = 2'b00;
  logic       done;
  logic [1:0] product;
  logic [1:0] change;

  int total = 0;
  int bad   = 0;

  vendig_machine #(.PRICE_CHOC(2), .PRICE_DRINK(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .choice  (choice),
    .coins   (coins),
    .done    (done),
    .product (product),
    .change  (change)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [9:0] step);
    rst    = step[9];
    start  = step[8];
    choice = step[7];
    coins  = step[6:5];
  endtask

  // Two reset cycles, reset beating start/coins, IDLE ignoring coins.
  task automatic test_reset;
    logic [9:0] v [3];
    v[0] = {1'b1, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    v[1] = {1'b1, 1'b1, 1'b1, 2'b11, 5'b0_00_00};
    v[2] = {1'b0, 1'b0, 1'b0, 2'b11, 5'b0_00_00};
    for (int i = 0; i < 3; i++) begin
      apply(v[i]);
      tick();
      total++;
      if ({done, product, change} !== v[i][4:0]) begin
        bad++;
        $display("FAIL reset step %0d: got done=%b product=%b change=%b, want %b", i, done, product, change, v[i][4:0]);
      end
    end
  endtask

  // Chocolate, waiting with no coins, then two 1-unit coins: exact payment.
  task automatic test_choc_exact;
    logic [9:0] v [7];
    v[0] = {1'b0, 1'b1, 1'b0, 2'b00, 5'b0_00_00};
    v[1] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    v[2] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    v[3] = {1'b0, 1'b1, 1'b1, 2'b00, 5'b0_00_00};
    v[4] = {1'b0, 1'b0, 1'b1, 2'b01, 5'b0_00_00};
    v[5] = {1'b0, 1'b0, 1'b1, 2'b01, 5'b1_01_00};
    v[6] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    for (int i = 0; i < 7; i++) begin
      apply(v[i]);
      tick();
      total++;
      if ({done, product, change} !== v[i][4:0]) begin
        bad++;
        $display("FAIL choc_exact step %0d: got done=%b product=%b change=%b, want %b", i, done, product, change, v[i][4:0]);
      end
    end
  endtask

  // Drink with two 2-unit coins: 4 - 3 = 1 change.
  task automatic test_drink_over;
    logic [9:0] v [4];
    v[0] = {1'b0, 1'b1, 1'b1, 2'b00, 5'b0_00_00};
    v[1] = {1'b0, 1'b0, 1'b0, 2'b10, 5'b0_00_00};
    v[2] = {1'b0, 1'b0, 1'b0, 2'b10, 5'b1_10_01};
    v[3] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    for (int i = 0; i < 4; i++) begin
      apply(v[i]);
      tick();
      total++;
      if ({done, product, change} !== v[i][4:0]) begin
        bad++;
        $display("FAIL drink_over step %0d: got done=%b product=%b change=%b, want %b", i, done, product, change, v[i][4:0]);
      end
    end
  endtask

  // Maximum overpayment for both products: change = 2.
  task automatic test_max_change;
    logic [9:0] v [8];
    v[0] = {1'b0, 1'b1, 1'b0, 2'b00, 5'b0_00_00};
    v[1] = {1'b0, 1'b0, 1'b0, 2'b01, 5'b0_00_00};
    v[2] = {1'b0, 1'b0, 1'b0, 2'b11, 5'b1_01_10};
    v[3] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    v[4] = {1'b0, 1'b1, 1'b1, 2'b00, 5'b0_00_00};
    v[5] = {1'b0, 1'b0, 1'b0, 2'b10, 5'b0_00_00};
    v[6] = {1'b0, 1'b0, 1'b0, 2'b11, 5'b1_10_10};
    v[7] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    for (int i = 0; i < 8; i++) begin
      apply(v[i]);
      tick();
      total++;
      if ({done, product, change} !== v[i][4:0]) begin
        bad++;
        $display("FAIL max_change step %0d: got done=%b product=%b change=%b, want %b", i, done, product, change, v[i][4:0]);
      end
    end
  endtask

  // start and 1-unit coins held high: coins in IDLE and DISPENSE add nothing,
  // so each drink sale lands on the third collecting edge, with a gap of
  // one IDLE cycle before the next purchase starts.
  task automatic test_back_to_back;
    logic [9:0] v [10];
    v[0] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b0_00_00};
    v[1] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b0_00_00};
    v[2] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b0_00_00};
    v[3] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b1_10_00};
    v[4] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b0_00_00};
    v[5] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b0_00_00};
    v[6] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b0_00_00};
    v[7] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b0_00_00};
    v[8] = {1'b0, 1'b1, 1'b1, 2'b01, 5'b1_10_00};
    v[9] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    for (int i = 0; i < 10; i++) begin
      apply(v[i]);
      tick();
      total++;
      if ({done, product, change} !== v[i][4:0]) begin
        bad++;
        $display("FAIL back_to_back step %0d: got done=%b product=%b change=%b, want %b", i, done, product, change, v[i][4:0]);
      end
    end
  endtask

  // Reset mid-collect with a coin that would have completed the chocolate
  // sale: no pulse, credit discarded; a new drink needs a full 3 units.
  task automatic test_reset_abort;
    logic [9:0] v [8];
    v[0] = {1'b0, 1'b1, 1'b0, 2'b00, 5'b0_00_00};
    v[1] = {1'b0, 1'b0, 1'b0, 2'b01, 5'b0_00_00};
    v[2] = {1'b1, 1'b0, 1'b0, 2'b01, 5'b0_00_00};
    v[3] = {1'b0, 1'b1, 1'b1, 2'b00, 5'b0_00_00};
    v[4] = {1'b0, 1'b0, 1'b0, 2'b10, 5'b0_00_00};
    v[5] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    v[6] = {1'b0, 1'b0, 1'b0, 2'b01, 5'b1_10_00};
    v[7] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b0_00_00};
    for (int i = 0; i < 8; i++) begin
      apply(v[i]);
      tick();
      total++;
      if ({done, product, change} !== v[i][4:0]) begin
        bad++;
        $display("FAIL reset_abort step %0d: got done=%b product=%b change=%b, want %b", i, done, product, change, v[i][4:0]);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_choc_exact();
    test_drink_over();
    test_max_change();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
